// File: rtl/airport_checkpoint_scheduler.sv
// airport_checkpoint_scheduler: multi-lane security checkpoint controller.
// Arrivals are queued in two classes (PRI = crew/VIP, STD = standard/reserved).
// At most one passenger per cycle is dispatched to the lowest-indexed IDLE lane.
// Each lane then runs a scan FSM that ends in CLEAR or FLAG, depending on bag parity.
// Every dispatch issues an LFSR-based security token.
// The last dispatch's class is reported on dispatch_priority, because "priority" is a reserved word.
// Optional feature: define STARVE_GUARD_EN to force one STD grant after STARVE_LIMIT
// consecutive PRI grants that were made while STD was waiting.
// Handshake: an arrival is taken on a rising edge where arr_valid && arr_ready.
// arr_ready reflects only whether the class selected by arr_type is full; it never depends on arr_valid.
// lane_state_dbg exposes each lane's FSM state (2 bits per lane) for checkers.
module airport_checkpoint_scheduler #(
  parameter int LANES        = 4,
  parameter int DEPTH        = 8,
  parameter int DATA_W       = 8,
  parameter int SCAN_CYC     = 4,
  parameter int STARVE_LIMIT = 4,
  localparam int LW          = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int CNT_W       = $clog2(2 * DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arr_valid,
  output logic                arr_ready,
  input  logic [1:0]          arr_type,
  input  logic [DATA_W-1:0]   arr_bag,
  input  logic [LANES-1:0]    flag_ack,
  output logic [LANES-1:0]    lane_busy,
  output logic [2*LANES-1:0]  light,
  output logic                dispatch_valid,
  output logic [LW-1:0]       dispatch_lane,
  output logic [1:0]          dispatch_priority,
  output logic [7:0]          security_token,
  output logic [CNT_W-1:0]    count,
  output logic [7:0]          flag_count,
  output logic [2*LANES-1:0]  lane_state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = PW + 1;
  localparam int CW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int EW = 2 + DATA_W;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYC - 1);
  localparam logic [QW-1:0] Q_FULL    = QW'(DEPTH);

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_SCAN  = 2'd1,
    L_CLEAR = 2'd2,
    L_FLAG  = 2'd3
  } lane_state_t;

  logic [EW-1:0] pri_mem [DEPTH];
  logic [EW-1:0] std_mem [DEPTH];
  logic [PW-1:0] pri_wp, pri_rp, std_wp, std_rp;
  logic [QW-1:0] pri_cnt, std_cnt;

  lane_state_t   lane_state [LANES];
  logic [CW-1:0] scan_cnt   [LANES];
  logic [LANES-1:0] lane_par;

  logic [7:0]        lfsr;
  logic              lfsr_fb;
  logic              arr_is_pri, pri_push, std_push;
  logic              idle_any;
  logic [LW-1:0]     free_lane;
  logic              force_std, grant_pri, grant_std, dispatch;
  logic [EW-1:0]     gnt_entry;
  logic [1:0]        gnt_type;
  logic [DATA_W-1:0] gnt_bag;
  logic [3:0]        flag_enter;
  logic [8:0]        flag_sum;

  // Class decode and per-class full test; reserved type 11 rides with STD.
  assign arr_is_pri = (arr_type == 2'b01) || (arr_type == 2'b10);
  assign arr_ready  = arr_is_pri ? (pri_cnt != Q_FULL) : (std_cnt != Q_FULL);
  assign pri_push   = arr_valid && arr_ready && arr_is_pri;
  assign std_push   = arr_valid && arr_ready && !arr_is_pri;
  assign count      = CNT_W'(pri_cnt) + CNT_W'(std_cnt);
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Count PRI grants taken while STD waits; any STD grant clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_std) begin
      starve_cnt <= '0;
    end else if (grant_pri && (std_cnt != '0) && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign force_std = (std_cnt != '0) && (starve_cnt == SW'(STARVE_LIMIT));
`else
  assign force_std = 1'b0;
`endif

  // Lowest-indexed IDLE lane: scan downward so the smallest index wins.
  always_comb begin
    idle_any  = 1'b0;
    free_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_state[i] == L_IDLE) begin
        idle_any  = 1'b1;
        free_lane = LW'(i);
      end
    end
  end

  // Grant selection: forced STD first, then PRI, then STD; queue heads are registered,
  // so a fresh arrival is never dispatched on the edge that stores it.
  always_comb begin
    grant_pri = 1'b0;
    grant_std = 1'b0;
    if (idle_any) begin
      if (force_std) begin
        grant_std = 1'b1;
      end else if (pri_cnt != '0) begin
        grant_pri = 1'b1;
      end else if (std_cnt != '0) begin
        grant_std = 1'b1;
      end
    end
    dispatch  = grant_pri || grant_std;
    gnt_entry = grant_pri ? pri_mem[pri_rp] : std_mem[std_rp];
    gnt_type  = gnt_entry[EW-1 -: 2];
    gnt_bag   = gnt_entry[DATA_W-1:0];
  end

  // Lanes entering FLAG this cycle, used for the saturating flag counter.
  always_comb begin
    flag_enter = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((lane_state[i] == L_SCAN) && (scan_cnt[i] == SCAN_LAST) && lane_par[i]) begin
        flag_enter = flag_enter + 4'd1;
      end
    end
    flag_sum = {1'b0, flag_count} + 9'(flag_enter);
  end

  // Busy flags and the debug view of the lane FSMs.
  always_comb begin
    lane_busy      = '0;
    lane_state_dbg = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_busy[i]             = (lane_state[i] != L_IDLE);
      lane_state_dbg[2*i +: 2] = lane_state[i];
    end
  end

  // Queue storage; entries hold {type, bag} and need no reset.
  always_ff @(posedge clk) begin
    if (pri_push) pri_mem[pri_wp] <= {arr_type, arr_bag};
    if (std_push) std_mem[std_wp] <= {arr_type, arr_bag};
  end

  // Queue pointers and occupancy; a push and a pop on the same edge are both honoured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pri_wp  <= '0;
      pri_rp  <= '0;
      std_wp  <= '0;
      std_rp  <= '0;
      pri_cnt <= '0;
      std_cnt <= '0;
    end else begin
      if (pri_push)  pri_wp <= pri_wp + PW'(1);
      if (grant_pri) pri_rp <= pri_rp + PW'(1);
      if (std_push)  std_wp <= std_wp + PW'(1);
      if (grant_std) std_rp <= std_rp + PW'(1);
      pri_cnt <= pri_cnt + QW'(pri_push) - QW'(grant_pri);
      std_cnt <= std_cnt + QW'(std_push) - QW'(grant_std);
    end
  end

  // Dispatch report, token generation (the LFSR advances only on dispatch), and flag counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dispatch_valid    <= 1'b0;
      dispatch_lane     <= '0;
      dispatch_priority <= 2'b00;
      security_token    <= 8'h00;
      lfsr              <= 8'hA5;
      flag_count        <= 8'h00;
    end else begin
      dispatch_valid <= dispatch;
      if (dispatch) begin
        dispatch_lane     <= free_lane;
        dispatch_priority <= gnt_type;
        security_token    <= lfsr ^ gnt_bag[7:0];
        lfsr              <= {lfsr[6:0], lfsr_fb};
      end
      flag_count <= flag_sum[8] ? 8'hFF : flag_sum[7:0];
    end
  end

  // Per-lane scan FSM with registered lights: IDLE -> SCAN -> CLEAR/FLAG -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        lane_state[i] <= L_IDLE;
        scan_cnt[i]   <= '0;
      end
      lane_par <= '0;
      light    <= {LANES{2'b01}};
    end else begin
      for (int i = 0; i < LANES; i++) begin
        case (lane_state[i])
          L_IDLE: begin
            if (dispatch && (free_lane == LW'(i))) begin
              lane_state[i]     <= L_SCAN;
              scan_cnt[i]       <= '0;
              lane_par[i]       <= ^gnt_bag;
              light[2*i +: 2]   <= 2'b10;
            end
          end
          L_SCAN: begin
            if (scan_cnt[i] == SCAN_LAST) begin
              if (lane_par[i]) begin
                lane_state[i]   <= L_FLAG;
                light[2*i +: 2] <= 2'b11;
              end else begin
                lane_state[i]   <= L_CLEAR;
                light[2*i +: 2] <= 2'b01;
              end
            end else begin
              scan_cnt[i] <= scan_cnt[i] + CW'(1);
            end
          end
          L_CLEAR: begin
            lane_state[i]   <= L_IDLE;
            light[2*i +: 2] <= 2'b01;
          end
          L_FLAG: begin
            if (flag_ack[i]) begin
              lane_state[i]   <= L_IDLE;
              light[2*i +: 2] <= 2'b01;
            end
          end
          default: begin
            lane_state[i]   <= L_IDLE;
            light[2*i +: 2] <= 2'b01;
          end
        endcase
      end
    end
  end

endmodule
